// File: rtl/midi_msg_ctrl.sv
// ---------------------------------------------------------------------------
// midi_msg_ctrl
//
// Turns the byte stream from the MIDI serial receiver into complete Note On /
// Note Off events. It tracks status bytes and running status, and filters on
// a listen channel. It assembles the two data bytes of a note message and
// offers the result on a valid/ready event port. A held-note register feeds
// the board LEDs.
//
// Optional feature macro: MIDI_RUNNING_STATUS_EN
//   defined   : channel status bytes are kept as running status, so data bytes
//               arriving in IDLE start a new message of the same type.
//   undefined : running status is never stored and data bytes in IDLE are
//               dropped, so every message needs its own status byte.
//
// Parameters:
//   CNT_W          timeout counter width
//   TIMEOUT_CYCLES idle cycles allowed between bytes of one message
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte
//   channel      listen channel, sampled when a status byte arrives
//   evt_ready    consumer accepts the pending event
//   evt_valid    event pending
//   evt_note_on  1 = Note On, 0 = Note Off (velocity 0 Note On reads as Off)
//   evt_note     note number
//   evt_vel      velocity
//   note_held    a note is currently sounding
//   active_note  note number of the last Note On
//   err_overflow sticky flag: a completed event was dropped
// ---------------------------------------------------------------------------
module midi_msg_ctrl #(
  parameter int unsigned       CNT_W          = 16,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 16'd25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [3:0] channel,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic       evt_note_on,
  output logic [6:0] evt_note,
  output logic [6:0] evt_vel,
  output logic       note_held,
  output logic [6:0] active_note,
  output logic       err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SKIP    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  // Last counter value before a partial message is abandoned.
  localparam logic [CNT_W-1:0] TO_LAST_C  = TIMEOUT_CYCLES - CNT_ONE_C;

  // Number of data bytes carried by a channel message of the given type.
  function automatic logic [1:0] data_len(input logic [3:0] kind);
    logic [1:0] len;
    if ((kind == 4'hC) || (kind == 4'hD)) begin
      len = 2'd1;
    end else begin
      len = 2'd2;
    end
    return len;
  endfunction

  // True for a Note On / Note Off status addressed to the listen channel.
  function automatic logic note_for_ch(input logic [7:0] status,
                                       input logic [3:0] ch);
    return (status[7:5] == 3'b100) && (status[3:0] == ch);
  endfunction

  // ---------------------------------------------------------------------
  // Registered parser state
  // ---------------------------------------------------------------------
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       skip_r, skip_s;
  logic             rs_valid_r, rs_valid_s;  // running status present
  logic [3:0]       rs_kind_r, rs_kind_s;    // running status message type
  logic             rs_match_r, rs_match_s;  // running status is our note msg
  logic             msg_on_r, msg_on_s;      // current message is type 0x9
  logic [6:0]       note_r, note_s;          // latched first data byte

  // Completion of a listened-to note message this cycle
  logic             cmpl_s;
  logic             cmpl_on_s;
  logic [6:0]       cmpl_note_s;
  logic [6:0]       cmpl_vel_s;

  // Byte classification
  logic             is_rt_s, is_sys_s, is_stat_s, is_data_s;
  logic             stat_match_s;

  // Classify the incoming byte.
  always_comb begin
    is_rt_s      = rx_valid && (rx_data[7:3] == 5'b11111);
    is_sys_s     = rx_valid && (rx_data[7:3] == 5'b11110);
    is_stat_s    = rx_valid && rx_data[7] && (rx_data[7:4] != 4'hF);
    is_data_s    = rx_valid && !rx_data[7];
    stat_match_s = note_for_ch(rx_data, channel);
  end

  // Next-state logic: status handling, data assembly, skipping and timeout.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    skip_s      = skip_r;
    rs_valid_s  = rs_valid_r;
    rs_kind_s   = rs_kind_r;
    rs_match_s  = rs_match_r;
    msg_on_s    = msg_on_r;
    note_s      = note_r;
    cmpl_s      = 1'b0;
    cmpl_note_s = note_r;
    cmpl_vel_s  = rx_data[6:0];
    cmpl_on_s   = msg_on_r && (rx_data[6:0] != 7'd0);

    if (is_stat_s) begin
      // A status byte always restarts parsing; any partial message is lost.
      cnt_s      = CNT_ZERO_C;
      rs_kind_s  = rx_data[7:4];
      rs_match_s = stat_match_s;
      msg_on_s   = (rx_data[7:4] == 4'h9);
`ifdef MIDI_RUNNING_STATUS_EN
      rs_valid_s = 1'b1;
`else
      rs_valid_s = 1'b0;
`endif
      if (stat_match_s) begin
        state_s = ST_WAIT_D1;
        skip_s  = 2'd0;
      end else begin
        state_s = ST_SKIP;
        skip_s  = data_len(rx_data[7:4]);
      end
    end else if (is_sys_s) begin
      cnt_s      = CNT_ZERO_C;
      rs_valid_s = 1'b0;
      state_s    = ST_IDLE;
      skip_s     = 2'd0;
    end else if (is_data_s) begin
      cnt_s = CNT_ZERO_C;
      case (state_r)
        ST_IDLE: begin
          // Running status: this byte is the first data byte of a new message.
          if (rs_valid_r) begin
            if (rs_match_r) begin
              note_s  = rx_data[6:0];
              state_s = ST_WAIT_D2;
            end else if (data_len(rs_kind_r) == 2'd1) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_SKIP;
              skip_s  = 2'd1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT_D1: begin
          note_s  = rx_data[6:0];
          state_s = ST_WAIT_D2;
        end
        ST_WAIT_D2: begin
          cmpl_s  = 1'b1;
          state_s = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_r <= 2'd1) begin
            skip_s  = 2'd0;
            state_s = ST_IDLE;
          end else begin
            skip_s  = skip_r - 2'd1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if ((state_r != ST_IDLE) && !is_rt_s) begin
      // No byte this cycle while a message is open: run the timeout.
      if (cnt_r >= TO_LAST_C) begin
        cnt_s   = CNT_ZERO_C;
        state_s = ST_IDLE;
        skip_s  = 2'd0;
      end else begin
        cnt_s   = cnt_r + CNT_ONE_C;
      end
    end else begin
      // Realtime byte or IDLE with nothing received: hold everything.
      cnt_s = cnt_r;
    end
  end

  // Parser state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO_C;
      skip_r     <= 2'd0;
      rs_valid_r <= 1'b0;
      rs_kind_r  <= 4'd0;
      rs_match_r <= 1'b0;
      msg_on_r   <= 1'b0;
      note_r     <= 7'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      skip_r     <= skip_s;
      rs_valid_r <= rs_valid_s;
      rs_kind_r  <= rs_kind_s;
      rs_match_r <= rs_match_s;
      msg_on_r   <= msg_on_s;
      note_r     <= note_s;
    end
  end

  // Event port, overflow flag and held-note register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid    <= 1'b0;
      evt_note_on  <= 1'b0;
      evt_note     <= 7'd0;
      evt_vel      <= 7'd0;
      note_held    <= 1'b0;
      active_note  <= 7'd0;
      err_overflow <= 1'b0;
    end else begin
      if (cmpl_s) begin
        // A new event may replace one that is being accepted this cycle.
        if (!evt_valid || evt_ready) begin
          evt_valid   <= 1'b1;
          evt_note_on <= cmpl_on_s;
          evt_note    <= cmpl_note_s;
          evt_vel     <= cmpl_vel_s;
        end else begin
          err_overflow <= 1'b1;
        end
        // The held note tracks every completed message, delivered or not.
        if (cmpl_on_s) begin
          active_note <= cmpl_note_s;
          note_held   <= 1'b1;
        end else if (cmpl_note_s == active_note) begin
          note_held   <= 1'b0;
        end else begin
          note_held   <= note_held;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end else begin
        evt_valid <= evt_valid;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_midi_msg_ctrl
//
// Self-checking bench for midi_msg_ctrl. A message-level reference model
// (byte counts per message type, a queue of collected data bytes, an idle
// cycle count) predicts the event port and held-note outputs. A compare
// process checks every output on every falling edge. Directed sequences with
// hand-computed expectations come first, followed by randomized byte traffic.
// ---------------------------------------------------------------------------
module tb_midi_msg_ctrl;

  localparam int T_INT = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] channel;
  logic       evt_ready;
  logic       evt_valid;
  logic       evt_note_on;
  logic [6:0] evt_note;
  logic [6:0] evt_vel;
  logic       note_held;
  logic [6:0] active_note;
  logic       err_overflow;

  midi_msg_ctrl #(.CNT_W(16), .TIMEOUT_CYCLES(16'd40)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .channel(channel), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_note_on(evt_note_on), .evt_note(evt_note), .evt_vel(evt_vel),
    .note_held(note_held), .active_note(active_note),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // ---------------- reference model ----------------
  logic       m_valid, m_on, m_held, m_err;
  logic [6:0] m_note, m_vel, m_active;
  int         m_rs;        // running status byte, -1 when none
  bit         m_rs_ok;     // running status was our note message when stored
  bit         m_cur_ok;    // open message is a note message for us
  bit         m_cur_on;    // open message is type 0x9
  int         m_need;      // data bytes the open message needs, 0 = none open
  int         m_idle;      // idle cycles since the last non-realtime byte
  logic [7:0] m_q[$];      // data bytes collected so far

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_start(input logic [7:0] s, input bit ok);
    m_cur_ok = ok;
    m_cur_on = (s[7:4] == 4'h9);
    m_need   = ((s[7:4] == 4'hC) || (s[7:4] == 4'hD)) ? 1 : 2;
    m_q.delete();
  endtask

  task automatic model_step();
    bit         done;
    bit         on;
    logic [6:0] nn, vv;
    logic [7:0] b;
    done = 1'b0; on = 1'b0; nn = 7'd0; vv = 7'd0;
    if (!rst_n) begin
      m_valid = 1'b0; m_on = 1'b0; m_note = 7'd0; m_vel = 7'd0;
      m_held = 1'b0; m_active = 7'd0; m_err = 1'b0;
      m_rs = -1; m_rs_ok = 1'b0; m_need = 0; m_idle = 0; m_q.delete();
      return;
    end
    if (rx_valid) begin
      b = rx_data;
      if (b >= 8'hF8) begin
        // realtime: invisible
      end else if (b >= 8'hF0) begin
        m_rs = -1; m_need = 0; m_idle = 0; m_q.delete();
      end else if (b >= 8'h80) begin
        m_idle = 0;
        m_start(b, (b[7:5] == 3'b100) && (b[3:0] == channel));
`ifdef MIDI_RUNNING_STATUS_EN
        m_rs = int'(b); m_rs_ok = m_cur_ok;
`endif
      end else begin
        m_idle = 0;
        if ((m_need == 0) && (m_rs >= 0)) m_start(m_rs[7:0], m_rs_ok);
        if (m_need > 0) begin
          m_q.push_back(b);
          if (m_q.size() == m_need) begin
            if (m_cur_ok) begin
              done = 1'b1;
              nn = m_q[0][6:0];
              vv = m_q[1][6:0];
              on = m_cur_on && (vv != 7'd0);
            end
            m_need = 0;
            m_q.delete();
          end
        end
      end
    end else if (m_need > 0) begin
      m_idle++;
      if (m_idle == T_INT) begin
        m_need = 0; m_idle = 0; m_q.delete();
      end
    end
    if (done) begin
      if (!m_valid || evt_ready) begin
        m_valid = 1'b1; m_on = on; m_note = nn; m_vel = vv;
      end else begin
        m_err = 1'b1;
      end
      if (on) begin
        m_active = nn; m_held = 1'b1;
      end else if (nn == m_active) begin
        m_held = 1'b0;
      end
    end else if (evt_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("evt_valid", {7'd0, evt_valid}, {7'd0, m_valid});
      if (m_valid) begin
        chk("evt_note_on", {7'd0, evt_note_on}, {7'd0, m_on});
        chk("evt_note", {1'b0, evt_note}, {1'b0, m_note});
        chk("evt_vel", {1'b0, evt_vel}, {1'b0, m_vel});
      end
      chk("note_held", {7'd0, note_held}, {7'd0, m_held});
      chk("active_note", {1'b0, active_note}, {1'b0, m_active});
      chk("err_overflow", {7'd0, err_overflow}, {7'd0, m_err});
    end
  end

  // One clock: drive at the falling edge, model the rising edge, return at
  // the next falling edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  // Hand-computed expectation checked against both DUT and model.
  task automatic pin(input string name, input logic [7:0] dv,
                     input logic [7:0] mv, input logic [7:0] exp);
    chk({name, "_dut"}, dv, exp);
    chk({name, "_model"}, mv, exp);
  endtask

  task automatic pin_evt(input string tag, input logic on,
                         input logic [6:0] n, input logic [6:0] v);
    pin({tag, "_valid"}, {7'd0, evt_valid}, {7'd0, m_valid}, 8'd1);
    pin({tag, "_on"}, {7'd0, evt_note_on}, {7'd0, m_on}, {7'd0, on});
    pin({tag, "_note"}, {1'b0, evt_note}, {1'b0, m_note}, {1'b0, n});
    pin({tag, "_vel"}, {1'b0, evt_vel}, {1'b0, m_vel}, {1'b0, v});
  endtask

  task automatic pin_noevt(input string tag);
    pin({tag, "_valid"}, {7'd0, evt_valid}, {7'd0, m_valid}, 8'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [3:0] kinds [9];
    logic [7:0] b;
    kinds = '{4'h8, 4'h9, 4'h9, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    r = $urandom_range(0, 99);
    if (r < 55) begin
      case ($urandom_range(0, 3))
        0: b = 8'h3C;
        1: b = 8'h00;
        2: b = 8'h3D;
        default: b = 8'($urandom_range(0, 127));
      endcase
    end else if (r < 77) begin
      b = {kinds[$urandom_range(0, 8)], 4'($urandom_range(0, 1))};
    end else if (r < 83) begin
      b = 8'($urandom_range(8'hF0, 8'hF7));
    end else begin
      b = 8'($urandom_range(8'hF8, 8'hFF));
    end
    return b;
  endfunction

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    channel = 4'd0; evt_ready = 1'b1;
    idle(3);
    cmp_en = 1'b1;
    pin("rst_valid", {7'd0, evt_valid}, {7'd0, m_valid}, 8'd0);
    pin("rst_note", {1'b0, evt_note}, {1'b0, m_note}, 8'd0);
    pin("rst_held", {7'd0, note_held}, {7'd0, m_held}, 8'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic Note On
    send(8'h90); send(8'h3C); send(8'h64);
    pin_evt("t1", 1'b1, 7'h3C, 7'h64);
    pin("t1_held", {7'd0, note_held}, {7'd0, m_held}, 8'd1);
    pin("t1_active", {1'b0, active_note}, {1'b0, m_active}, 8'h3C);

    // Running status Note On velocity 0
    send(8'h3C); send(8'h00);
`ifdef MIDI_RUNNING_STATUS_EN
    pin_evt("t2", 1'b0, 7'h3C, 7'h00);
    pin("t2_held", {7'd0, note_held}, {7'd0, m_held}, 8'd0);
`else
    pin_noevt("t2");
    pin("t2_held", {7'd0, note_held}, {7'd0, m_held}, 8'd1);
`endif
    idle(2);

    // Other channel and program change are skipped; then a Note Off
    send(8'h91); send(8'h40); send(8'h40); send(8'hC0); send(8'h05);
    pin_noevt("t3a");
    send(8'h80); send(8'h40); send(8'h00);
    pin_evt("t3b", 1'b0, 7'h40, 7'h00);
`ifdef MIDI_RUNNING_STATUS_EN
    pin("t3_held", {7'd0, note_held}, {7'd0, m_held}, 8'd0);
`else
    pin("t3_held", {7'd0, note_held}, {7'd0, m_held}, 8'd1);
`endif
    idle(2);

    // Realtime bytes interleaved, back-to-back strobes
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h50);
    pin_evt("t4", 1'b1, 7'h3C, 7'h50);
    idle(2);

    // Overflow with consumer stalled
    evt_ready = 1'b0;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h90); send(8'h3D); send(8'h22);
    pin_evt("t5", 1'b1, 7'h3C, 7'h64);
    pin("t5_err", {7'd0, err_overflow}, {7'd0, m_err}, 8'd1);
    pin("t5_active", {1'b0, active_note}, {1'b0, m_active}, 8'h3D);
    evt_ready = 1'b1;
    idle(1);
    pin_noevt("t5_drain");

    // Reset mid-message clears everything including the sticky error
    send(8'h90); send(8'h3C);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    send(8'h64);
    pin_noevt("t6");
    pin("t6_err", {7'd0, err_overflow}, {7'd0, m_err}, 8'd0);
    pin("t6_held", {7'd0, note_held}, {7'd0, m_held}, 8'd0);

    // Timeout boundary: one cycle short of the limit still completes
    send(8'h90); send(8'h3C); idle(T_INT - 1); send(8'h50);
    pin_evt("t7a", 1'b1, 7'h3C, 7'h50);
    idle(2);
    // Full timeout discards the partial message
    send(8'h90); send(8'h3C); idle(T_INT); send(8'h50);
    pin_noevt("t7b");
    idle(2);

    // Status byte mid-message restarts at the first data byte
    send(8'h90); send(8'h3C); send(8'h80);
    pin_noevt("t8a");
    send(8'h41); send(8'h42);
    pin_evt("t8b", 1'b0, 7'h41, 7'h42);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) channel = 4'($urandom_range(0, 1));
      if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
      end else if ($urandom_range(0, 99) < 2) begin
        idle(T_INT - 2 + $urandom_range(0, 3));
      end else if ($urandom_range(0, 9) < 7) begin
        send(rand_byte());
      end else begin
        idle(1);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_msg_ctrl.md
# midi_msg_ctrl

MIDI message controller that sits after the serial byte receiver and sequences its byte stream into complete channel-voice note events. It tracks status/running status, filters by a configurable channel, assembles Note On/Note Off messages, and presents them on a valid/ready event port. It also keeps a held-note register that drives the board LEDs.

## Interface
- TIMEOUT_CYCLES, 16'd25000: idle cycles allowed between bytes of one message before it is aborted.
- CNT_W, 16: timeout counter width; TIMEOUT_CYCLES must fit in CNT_W bits.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_data  in  8  received byte; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- channel  in  4  listen channel (0-15); sampled when each status byte arrives.
- evt_ready  in  1  consumer accepts the event.
- evt_valid  out  1  event pending.
- evt_note_on  out  1  1 = Note On, 0 = Note Off.
- evt_note  out  7  note number.
- evt_vel  out  7  velocity.
- note_held  out  1  a note is currently sounding.
- active_note  out  7  last Note On note number.
- err_overflow  out  1  sticky: an event was dropped.

## Operation
- Byte classes: 0xF8-0xFF realtime: ignored, no state or counter change. 0xF0-0xF7 system common/exclusive: running status cleared, go IDLE, subsequent data bytes dropped. 0x80-0xEF channel status. 0x00-0x7F data.
- States: IDLE, WAIT_D1, WAIT_D2, SKIP.
- Channel status byte (any state): stored as running status. Type 0x8/0x9 with low nibble == channel -> WAIT_D1. Any other channel status -> SKIP with skip count 1 (types 0xC, 0xD) or 2 (all others). A status byte mid-message aborts the partial message silently.
- IDLE + data byte: with running status, treated as D1 (same rules as after the status byte); without it, dropped.
- WAIT_D1 + data: latch note, -> WAIT_D2. WAIT_D2 + data: latch velocity, complete message, -> IDLE.
- SKIP + data: decrement skip count; at 0 -> IDLE.
- Note On with velocity 0 is a Note Off.
- Completion: if evt_valid=0 or evt_ready=1 in the same cycle, load event registers and assert evt_valid; otherwise drop the new event and set err_overflow.
- evt_valid stays high with stable evt_* until a cycle with evt_ready=1; clears next cycle unless a new event loads in that cycle.
- Held note: Note On -> active_note=note, note_held=1. Note Off with note == active_note -> note_held=0; other notes leave it unchanged. Updated on completion even if the event was dropped.
- Timeout: counter clears on every non-realtime byte; increments in WAIT_D1/WAIT_D2/SKIP; at TIMEOUT_CYCLES-1 -> IDLE, partial message discarded, running status kept. Counter held at 0 in IDLE.

## Timing
- Reset values: evt_valid=0, evt_note_on=0, evt_note=0, evt_vel=0, note_held=0, active_note=0, err_overflow=0; state IDLE; running status invalid; counter 0.
- Latency: evt_valid rises the clock edge after the rx_valid cycle carrying the final data byte (1 cycle).
- note_held/active_note update on the same edge as evt_valid.
- rx_valid on consecutive cycles must be handled back-to-back, with no byte lost.
- Reset mid-message or with an event pending: everything returns to reset values and the pending event is lost.
- err_overflow clears only on reset.

## Configuration
- MIDI_RUNNING_STATUS_EN defined: running status behaves as above.
- Undefined: running status is never stored; data bytes in IDLE are always dropped; every message requires its own status byte.

## Test plan
- channel=0, bytes 0x90,0x3C,0x64, evt_ready=1 -> one evt_valid pulse, note_on=1, note=0x3C, vel=0x64; note_held=1, active_note=0x3C.
- Then 0x3C,0x00 (running status) -> event note_on=0, note=0x3C, vel=0; note_held=0. With macro undefined: no event.
- channel=0, bytes 0x91,0x40,0x40, then 0xC0,0x05 -> no events; next 0x80,0x40,0x00 -> Note Off event.
- 0x90,0xF8,0x3C,0xFE,0x50 back-to-back strobes -> single Note On note=0x3C vel=0x50.
- evt_ready=0, two complete Note Ons -> first held stable, second dropped, err_overflow=1; evt_ready=1 -> evt_valid low the next cycle.
- 0x90,0x3C then TIMEOUT_CYCLES idle, then 0x50 -> no event (0x50 starts a new running-status D1); 0x90,0x3C then 0x80 mid-message -> no event, state WAIT_D1.
